// File: rtl/proc_cont_sched.sv
// Shares one signal-store write port between procedural segments and continuous-assignment updates.
// Procedural segments run atomically; pending continuous updates drain fully before the next one.
module proc_cont_sched #(
  parameter int unsigned NPROC    = 4,
  parameter int unsigned NCONT    = 4,
  parameter int unsigned MAX_CONT = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [NPROC-1:0] proc_req,
  input  logic [NPROC-1:0] proc_done,
  output logic [NPROC-1:0] proc_gnt,
  input  logic [NCONT-1:0] cont_req,
  output logic [NCONT-1:0] cont_gnt,
  output logic [1:0]       phase,
  output logic             err_loop
);

  localparam int unsigned PW = (NPROC > 1) ? $clog2(NPROC) : 1;
  localparam int unsigned CW = (NCONT > 1) ? $clog2(NCONT) : 1;
  localparam int unsigned KW = $clog2(MAX_CONT + 1);

  typedef enum logic [1:0] {
    StIdle = 2'b00,
    StProc = 2'b01,
    StCont = 2'b10
  } phase_e;

  phase_e          phase_q, phase_d;
  logic [NPROC-1:0] proc_gnt_q, proc_gnt_d;
  logic [NCONT-1:0] cont_gnt_q, cont_gnt_d;
  logic [PW-1:0]   proc_ptr_q, proc_ptr_d;
  logic [PW-1:0]   proc_own_q, proc_own_d;
  logic [CW-1:0]   cont_ptr_q, cont_ptr_d;
  logic [KW-1:0]   cnt_q, cnt_d;
  logic            err_q, err_d;

  logic            proc_any, cont_any;
  logic [PW-1:0]   proc_win, pidx;
  logic [CW-1:0]   cont_win, cidx;
  logic            grant_cont;

  // Round-robin search: lowest index at or after the pointer, wrapping to 0.
  always_comb begin
    proc_any = 1'b0;
    proc_win = '0;
    pidx     = '0;
    for (int unsigned i = 0; i < NPROC; i++) begin
      pidx = PW'((32'(proc_ptr_q) + i) % NPROC);
      if (!proc_any && proc_req[pidx]) begin
        proc_any = 1'b1;
        proc_win = pidx;
      end
    end
  end

  always_comb begin
    cont_any = 1'b0;
    cont_win = '0;
    cidx     = '0;
    for (int unsigned i = 0; i < NCONT; i++) begin
      cidx = CW'((32'(cont_ptr_q) + i) % NCONT);
      if (!cont_any && cont_req[cidx]) begin
        cont_any = 1'b1;
        cont_win = cidx;
      end
    end
  end

  always_comb begin
    phase_d    = phase_q;
    proc_gnt_d = proc_gnt_q;
    cont_gnt_d = '0;
    proc_ptr_d = proc_ptr_q;
    proc_own_d = proc_own_q;
    cont_ptr_d = cont_ptr_q;
    cnt_d      = cnt_q;
    err_d      = err_q;
    grant_cont = 1'b0;

    unique case (phase_q)
      StIdle: begin
        if (cont_any) begin
          grant_cont = 1'b1;
          cnt_d      = KW'(1);
          phase_d    = StCont;
        end else if (proc_any) begin
          proc_gnt_d           = '0;
          proc_gnt_d[proc_win] = 1'b1;
          proc_own_d           = proc_win;
          phase_d              = StProc;
        end
      end
      StProc: begin
        // Only the owner's done ends the segment; all requests wait meanwhile.
        if (proc_done[proc_own_q]) begin
          proc_gnt_d = '0;
          proc_ptr_d = (proc_own_q == PW'(NPROC - 1)) ? '0 : proc_own_q + 1'b1;
          if (cont_any) begin
            grant_cont = 1'b1;
            cnt_d      = KW'(1);
            phase_d    = StCont;
          end else begin
            phase_d = StIdle;
          end
        end
      end
      StCont: begin
        if (!cont_any) begin
          cnt_d   = '0;
          phase_d = StIdle;
        end else if (cnt_q == KW'(MAX_CONT)) begin
          err_d   = 1'b1;
          cnt_d   = '0;
          phase_d = StIdle;
        end else begin
          grant_cont = 1'b1;
          cnt_d      = cnt_q + 1'b1;
        end
      end
      default: begin
        proc_gnt_d = '0;
        cnt_d      = '0;
        phase_d    = StIdle;
      end
    endcase

    if (grant_cont) begin
      cont_gnt_d[cont_win] = 1'b1;
      cont_ptr_d = (cont_win == CW'(NCONT - 1)) ? '0 : cont_win + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      phase_q    <= StIdle;
      proc_gnt_q <= '0;
      cont_gnt_q <= '0;
      proc_ptr_q <= '0;
      proc_own_q <= '0;
      cont_ptr_q <= '0;
      cnt_q      <= '0;
      err_q      <= 1'b0;
    end else begin
      phase_q    <= phase_d;
      proc_gnt_q <= proc_gnt_d;
      cont_gnt_q <= cont_gnt_d;
      proc_ptr_q <= proc_ptr_d;
      proc_own_q <= proc_own_d;
      cont_ptr_q <= cont_ptr_d;
      cnt_q      <= cnt_d;
      err_q      <= err_d;
    end
  end

  assign proc_gnt = proc_gnt_q;
  assign cont_gnt = cont_gnt_q;
  assign phase    = phase_q;
  assign err_loop = err_q;

endmodule

// File: tb/tb_proc_cont_sched.sv
// Scenario bench for proc_cont_sched (NPROC=4, NCONT=4, MAX_CONT=4); expected grants are
// queued when stimulus is applied and popped as the DUT issues grants.
module tb_proc_cont_sched;

  logic       clk;
  logic       rst_n;
  logic [3:0] proc_req;
  logic [3:0] proc_done;
  logic [3:0] proc_gnt;
  logic [3:0] cont_req;
  logic [3:0] cont_gnt;
  logic [1:0] phase;
  logic       err_loop;

  int checks = 0;
  int errors = 0;
  logic [7:0] exp_q[$];

  proc_cont_sched #(
    .NPROC   (4),
    .NCONT   (4),
    .MAX_CONT(4)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .proc_req (proc_req),
    .proc_done(proc_done),
    .proc_gnt (proc_gnt),
    .cont_req (cont_req),
    .cont_gnt (cont_gnt),
    .phase    (phase),
    .err_loop (err_loop)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n     = 1'b0;
    proc_req  = '0;
    proc_done = '0;
    cont_req  = '0;
    step();
    step();
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    rst_n     = 1'b0;
    proc_req  = 4'b1111;
    proc_done = '0;
    cont_req  = 4'b1111;
    step();
    step();
    checks += 4;
    if (proc_gnt !== 4'b0000) begin
      errors++; $display("FAIL reset_proc_gnt got %b want 0000", proc_gnt);
    end
    if (cont_gnt !== 4'b0000) begin
      errors++; $display("FAIL reset_cont_gnt got %b want 0000", cont_gnt);
    end
    if (phase !== 2'b00) begin
      errors++; $display("FAIL reset_phase got %b want 00", phase);
    end
    if (err_loop !== 1'b0) begin
      errors++; $display("FAIL reset_err got %b want 0", err_loop);
    end
  endtask

  task automatic test_reset_mid_proc();
    do_reset();
    proc_req = 4'b0100;
    step();
    checks += 2;
    if (proc_gnt !== 4'b0100) begin
      errors++; $display("FAIL midrst_grant got %b want 0100", proc_gnt);
    end
    if (phase !== 2'b01) begin
      errors++; $display("FAIL midrst_phase_proc got %b want 01", phase);
    end
    rst_n = 1'b0;
    #2;
    checks += 2;
    if (proc_gnt !== 4'b0000) begin
      errors++; $display("FAIL midrst_async_gnt got %b want 0000", proc_gnt);
    end
    if (phase !== 2'b00) begin
      errors++; $display("FAIL midrst_async_phase got %b want 00", phase);
    end
    #3;
    rst_n    = 1'b1;
    proc_req = 4'b0001;
    step();
    checks++;
    if (proc_gnt !== 4'b0001) begin
      errors++; $display("FAIL midrst_after_release got %b want 0001", proc_gnt);
    end
  endtask

  task automatic test_no_interleave();
    logic [7:0] e;
    do_reset();
    proc_req = 4'b0001;
    step();
    checks++;
    if (proc_gnt !== 4'b0001) begin
      errors++; $display("FAIL noint_grant got %b want 0001", proc_gnt);
    end
    proc_req = 4'b0000;
    cont_req = 4'b0011;
    for (int c = 1; c <= 6; c++) begin
      step();
      checks += 2;
      if (cont_gnt !== 4'b0000) begin
        errors++; $display("FAIL noint_cont_blocked cyc %0d got %b want 0000", c, cont_gnt);
      end
      if (proc_gnt !== 4'b0001) begin
        errors++; $display("FAIL noint_proc_held cyc %0d got %b want 0001", c, proc_gnt);
      end
    end
    exp_q.push_back({4'b0000, 4'b0001});
    exp_q.push_back({4'b0000, 4'b0010});
    proc_done = 4'b0001;
    for (int c = 0; c < 10 && exp_q.size() > 0; c++) begin
      step();
      proc_done = 4'b0000;
      if (cont_gnt !== 4'b0000) begin
        e = exp_q.pop_front();
        checks++;
        if ({proc_gnt, cont_gnt} !== e) begin
          errors++; $display("FAIL noint_drain got %b want %b", {proc_gnt, cont_gnt}, e);
        end
        cont_req = cont_req & ~cont_gnt;
      end
    end
    if (exp_q.size() != 0) begin
      checks++; errors++;
      $display("FAIL noint_timeout got %0d grants pending want 0", exp_q.size());
      exp_q.delete();
    end
    step();
    checks++;
    if (phase !== 2'b00) begin
      errors++; $display("FAIL noint_idle got %b want 00", phase);
    end
  endtask

  task automatic test_proc_rr();
    logic [7:0] e;
    do_reset();
    proc_req = 4'b1111;
    exp_q.push_back({4'b0001, 4'b0000});
    exp_q.push_back({4'b0010, 4'b0000});
    exp_q.push_back({4'b0100, 4'b0000});
    exp_q.push_back({4'b1000, 4'b0000});
    exp_q.push_back({4'b0001, 4'b0000});
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      step();
      checks += 2;
      if ({proc_gnt, cont_gnt} !== e) begin
        errors++; $display("FAIL prr_grant got %b want %b", {proc_gnt, cont_gnt}, e);
      end
      if (phase !== 2'b01) begin
        errors++; $display("FAIL prr_phase got %b want 01", phase);
      end
      step();
      checks++;
      if (proc_gnt !== e[7:4]) begin
        errors++; $display("FAIL prr_hold got %b want %b", proc_gnt, e[7:4]);
      end
      proc_done = e[7:4];
      step();
      proc_done = 4'b0000;
      checks++;
      if ({proc_gnt, phase} !== 6'b0000_00) begin
        errors++; $display("FAIL prr_idle_gap got gnt %b phase %b want 0000 00", proc_gnt, phase);
      end
    end
    proc_req = 4'b0000;
  endtask

  task automatic test_cont_priority();
    logic [7:0] e;
    do_reset();
    proc_req = 4'b0001;
    cont_req = 4'b0100;
    exp_q.push_back({4'b0000, 4'b0100});
    exp_q.push_back({4'b0000, 4'b0000});
    exp_q.push_back({4'b0001, 4'b0000});
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      step();
      checks++;
      if ({proc_gnt, cont_gnt} !== e) begin
        errors++; $display("FAIL prio_seq got %b want %b", {proc_gnt, cont_gnt}, e);
      end
      cont_req = cont_req & ~cont_gnt;
    end
    proc_req  = 4'b0000;
    proc_done = 4'b0001;
    step();
    proc_done = 4'b0000;
  endtask

  task automatic test_cont_rr(input logic [3:0] init, input bit retrigger, input string tag);
    logic [7:0] e;
    do_reset();
    cont_req = init;
    if (retrigger) begin
      exp_q.push_back({4'b0000, 4'b0100});
      exp_q.push_back({4'b0000, 4'b1000});
      exp_q.push_back({4'b0000, 4'b0001});
    end else begin
      exp_q.push_back({4'b0000, 4'b0001});
      exp_q.push_back({4'b0000, 4'b0010});
      exp_q.push_back({4'b0000, 4'b0100});
      exp_q.push_back({4'b0000, 4'b1000});
    end
    for (int c = 0; c < 20 && exp_q.size() > 0; c++) begin
      step();
      e = exp_q.pop_front();
      checks++;
      if ({proc_gnt, cont_gnt} !== e) begin
        errors++; $display("FAIL %s_grant got %b want %b", tag, {proc_gnt, cont_gnt}, e);
      end
      if (retrigger && cont_gnt == 4'b0100) cont_req = (cont_req & ~cont_gnt) | 4'b0001;
      else cont_req = cont_req & ~cont_gnt;
    end
    step();
    checks += 2;
    if (phase !== 2'b00) begin
      errors++; $display("FAIL %s_idle got %b want 00", tag, phase);
    end
    if (err_loop !== 1'b0) begin
      errors++; $display("FAIL %s_no_err got %b want 0", tag, err_loop);
    end
  endtask

  task automatic test_foreign_done();
    do_reset();
    proc_req = 4'b0010;
    step();
    proc_req  = 4'b0000;
    proc_done = 4'b0001;
    step();
    proc_done = 4'b0000;
    checks += 2;
    if (proc_gnt !== 4'b0010) begin
      errors++; $display("FAIL foreign_held got %b want 0010", proc_gnt);
    end
    if (phase !== 2'b01) begin
      errors++; $display("FAIL foreign_phase got %b want 01", phase);
    end
    proc_done = 4'b0010;
    step();
    proc_done = 4'b0000;
    checks++;
    if ({proc_gnt, phase} !== 6'b0000_00) begin
      errors++; $display("FAIL foreign_release got gnt %b phase %b want 0000 00", proc_gnt, phase);
    end
  endtask

  task automatic test_loop();
    do_reset();
    cont_req = 4'b0001;
    for (int c = 1; c <= 4; c++) begin
      step();
      checks += 2;
      if (cont_gnt !== 4'b0001) begin
        errors++; $display("FAIL loop_grant %0d got %b want 0001", c, cont_gnt);
      end
      if (err_loop !== 1'b0) begin
        errors++; $display("FAIL loop_early_err %0d got %b want 0", c, err_loop);
      end
    end
    step();
    checks += 3;
    if (cont_gnt !== 4'b0000) begin
      errors++; $display("FAIL loop_no_fifth got %b want 0000", cont_gnt);
    end
    if (err_loop !== 1'b1) begin
      errors++; $display("FAIL loop_err_set got %b want 1", err_loop);
    end
    if (phase !== 2'b00) begin
      errors++; $display("FAIL loop_idle got %b want 00", phase);
    end
    cont_req = 4'b0000;
    step();
    step();
    step();
    checks++;
    if (err_loop !== 1'b1) begin
      errors++; $display("FAIL loop_sticky got %b want 1", err_loop);
    end
    rst_n = 1'b0;
    #1;
    checks++;
    if (err_loop !== 1'b0) begin
      errors++; $display("FAIL loop_cleared got %b want 0", err_loop);
    end
    rst_n = 1'b1;
  endtask

  initial begin
    test_reset();
    test_reset_mid_proc();
    test_no_interleave();
    test_proc_rr();
    test_cont_priority();
    test_cont_rr(4'b1111, 1'b0, "crr");
    test_cont_rr(4'b1100, 1'b1, "cwrap");
    test_foreign_done();
    test_loop();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
